// File: rtl/pattern_packet_encoder_if.sv
// pattern_packet_encoder_if: channel config request plus the byte/done-tick handshake to the UART transmitter.
interface pattern_packet_encoder_if #(parameter int DATA_BIT = 32);
  logic                i_start;
  logic [DATA_BIT-1:0] i_output_pattern;
  logic [DATA_BIT-1:0] i_freq_pattern;
  logic [3:0]          i_sel_out;
  logic                i_ch_start;
  logic                i_ch_stop;
  logic                i_ch_mode;
  logic                i_tx_done_tick;
  logic [7:0]          o_tx_data;
  logic                o_tx_start;
  logic                o_busy;
  logic                o_done_tick;
  logic                o_frame_done_tick;
  modport master (
    output i_start, i_output_pattern, i_freq_pattern, i_sel_out,
           i_ch_start, i_ch_stop, i_ch_mode, i_tx_done_tick,
    input  o_tx_data, o_tx_start, o_busy, o_done_tick, o_frame_done_tick
  );
  modport slave (
    input  i_start, i_output_pattern, i_freq_pattern, i_sel_out,
           i_ch_start, i_ch_stop, i_ch_mode, i_tx_done_tick,
    output o_tx_data, o_tx_start, o_busy, o_done_tick, o_frame_done_tick
  );
endinterface

// File: rtl/pattern_packet_encoder.sv
// pattern_packet_encoder: serializes one channel's configuration into a PACK_NUM-byte packet for the UART transmitter.
module pattern_packet_encoder #(
  parameter int DATA_BIT   = 32,
  parameter int PACK_NUM   = 9,
  parameter int OUTPUT_NUM = 16
) (
  input logic clk,
  input logic rst,
  pattern_packet_encoder_if.slave bus
);
  localparam int CW = $clog2(PACK_NUM);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_BIT-1:0] out_q, freq_q;
  logic [3:0]          sel_q;
  logic [2:0]          flags_q;
  logic [PACK_NUM*8-1:0] pkt;
  logic                last;
  assign pkt  = {sel_q, 1'b0, flags_q, freq_q, out_q};
  assign last = cnt_q == CW'(PACK_NUM - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      freq_q  <= '0;
      sel_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bus.i_start) begin
        out_q   <= bus.i_output_pattern;
        freq_q  <= bus.i_freq_pattern;
        sel_q   <= bus.i_sel_out;
        flags_q <= {bus.i_ch_mode, bus.i_ch_stop, bus.i_ch_start};
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.i_start) begin
        state_d = S_SEND;
        cnt_d   = '0;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: if (bus.i_tx_done_tick) begin
        state_d = last ? S_DONE : S_SEND;
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // byte select only moves on the edge into S_SEND, so the data is stable through S_WAIT
  assign bus.o_tx_data         = pkt[{cnt_q, 3'b000} +: 8];
  assign bus.o_tx_start        = state_q == S_SEND;
  assign bus.o_busy            = state_q != S_IDLE;
  assign bus.o_done_tick       = state_q == S_DONE;
  assign bus.o_frame_done_tick = state_q == S_DONE && sel_q == 4'(OUTPUT_NUM - 1);
endmodule

// File: tb/tb_pattern_packet_encoder.sv
// tb_pattern_packet_encoder: directed scenarios with a byte monitor and a reference packet decoder.
module tb_pattern_packet_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] bytes_q[$];
  int stamps_q[$];
  int dones = 0;
  int frames = 0;
  int coinc = 0;

  pattern_packet_encoder_if #(.DATA_BIT(32)) bus ();
  pattern_packet_encoder #(.DATA_BIT(32), .PACK_NUM(9), .OUTPUT_NUM(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      bytes_q.push_back(bus.o_tx_data);
      stamps_q.push_back(cyc);
    end
    if (bus.o_done_tick) dones++;
    if (bus.o_frame_done_tick) begin
      frames++;
      if (bus.o_done_tick) coinc++;
    end
  end

  task automatic clear_mon();
    bytes_q.delete();
    stamps_q.delete();
    dones = 0;
    frames = 0;
    coinc = 0;
  endtask

  // caller is at posedge+1; returns at posedge+1 of the S_SEND cycle
  task automatic pulse_start(input logic [31:0] o, input logic [31:0] f, input logic [3:0] s,
                             input logic st, input logic sp, input logic md);
    bus.i_output_pattern = o;
    bus.i_freq_pattern = f;
    bus.i_sel_out = s;
    bus.i_ch_start = st;
    bus.i_ch_stop = sp;
    bus.i_ch_mode = md;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tx_start_timeout: got no o_tx_start, required one within 100 cycles");
    end
  endtask

  // answers n transmitter starts with a done tick dly cycles into S_WAIT; drop_at injects a busy i_start
  task automatic serve(input int n, input int dly, input int drop_at);
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_tx(ok);
      if (!ok) return;
      @(posedge clk); #1;
      if (k == drop_at) begin
        bus.i_start = 1'b1;
        bus.i_output_pattern = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
      end
      repeat (dly - (k == drop_at ? 1 : 0)) begin
        @(posedge clk); #1;
      end
      bus.i_tx_done_tick = 1'b1;
      @(posedge clk); #1;
      bus.i_tx_done_tick = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.o_done_tick) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got no o_done_tick, required one within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", bus.o_tx_data); end
    if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, required 0", bus.o_tx_start); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.o_busy); end
    if (bus.o_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.o_done_tick); end
    if (bus.o_frame_done_tick !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b, required 0", bus.o_frame_done_tick); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] exp [9] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h55};
    clear_mon();
    pulse_start(32'h12345678, 32'h000000FF, 4'd5, 1'b1, 1'b0, 1'b1);
    serve(9, 10, -1);
    wait_done();
    checks += 4;
    if (bytes_q.size() != 9) begin errors++; $display("FAIL single_count: got %0d starts, required 9", bytes_q.size()); end
    if (dones != 1) begin errors++; $display("FAIL single_done: got %0d, required 1", dones); end
    if (frames != 0) begin errors++; $display("FAIL single_frame: got %0d, required 0", frames); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b, required 0", bus.o_busy); end
    for (int k = 0; k < 9 && k < bytes_q.size(); k++) begin
      checks++;
      if (bytes_q[k] !== exp[k]) begin errors++; $display("FAIL single_byte%0d: got %h, required %h", k, bytes_q[k], exp[k]); end
    end
  endtask

  task automatic test_frame_end();
    clear_mon();
    pulse_start(32'hCAFEF00D, 32'h13572468, 4'd15, 1'b0, 1'b1, 1'b0);
    serve(9, 0, -1);
    wait_done();
    checks += 4;
    if (bytes_q.size() != 9) begin errors++; $display("FAIL frame_count: got %0d starts, required 9", bytes_q.size()); end
    else if (bytes_q[8] !== 8'hF2) begin errors++; $display("FAIL frame_byte8: got %h, required f2", bytes_q[8]); end
    if (frames != 1) begin errors++; $display("FAIL frame_tick: got %0d, required 1", frames); end
    if (coinc != 1) begin errors++; $display("FAIL frame_with_done: got %0d, required 1", coinc); end
    if (dones != 1) begin errors++; $display("FAIL frame_done: got %0d, required 1", dones); end
  endtask

  task automatic test_busy_drop();
    logic [7:0] exp [9] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h55};
    clear_mon();
    pulse_start(32'h12345678, 32'h000000FF, 4'd5, 1'b1, 1'b0, 1'b1);
    serve(9, 10, 3);
    wait_done();
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (bytes_q.size() != 9) begin errors++; $display("FAIL drop_count: got %0d starts, required 9", bytes_q.size()); end
    if (dones != 1) begin errors++; $display("FAIL drop_done: got %0d, required 1", dones); end
    for (int k = 0; k < 9 && k < bytes_q.size(); k++) begin
      checks++;
      if (bytes_q[k] !== exp[k]) begin errors++; $display("FAIL drop_byte%0d: got %h, required %h", k, bytes_q[k], exp[k]); end
    end
  endtask

  task automatic test_handshake();
    logic [7:0] exp [9] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h31};
    clear_mon();
    pulse_start(32'h11223344, 32'hAABBCCDD, 4'd3, 1'b1, 1'b0, 1'b0);
    bus.i_tx_done_tick = 1'b1;
    @(posedge clk); #1;
    bus.i_tx_done_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL hs_send_tick_ignored: got tx_start %b, required 0", bus.o_tx_start); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL hs_still_waiting: got tx_start %b, required 0", bus.o_tx_start); end
    if (bus.o_tx_data !== 8'h44) begin errors++; $display("FAIL hs_data_held: got %h, required 44", bus.o_tx_data); end
    @(posedge clk); #1;
    bus.i_tx_done_tick = 1'b1;
    @(posedge clk); #1;
    bus.i_tx_done_tick = 1'b0;
    serve(8, 0, -1);
    wait_done();
    checks++;
    if (stamps_q.size() != 9) begin errors++; $display("FAIL hs_count: got %0d starts, required 9", stamps_q.size()); end
    else begin
      checks++;
      if (stamps_q[1] - stamps_q[0] != 4) begin errors++; $display("FAIL hs_gap0: got %0d cycles, required 4", stamps_q[1] - stamps_q[0]); end
      for (int k = 2; k < 9; k++) begin
        checks++;
        if (stamps_q[k] - stamps_q[k-1] != 2) begin errors++; $display("FAIL hs_gap%0d: got %0d cycles, required 2", k, stamps_q[k] - stamps_q[k-1]); end
      end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (bytes_q[k] !== exp[k]) begin errors++; $display("FAIL hs_byte%0d: got %h, required %h", k, bytes_q[k], exp[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h00, 8'h00, 8'h01, 8'hA6};
    clear_mon();
    pulse_start(32'h55667788, 32'h99AABBCC, 4'd7, 1'b1, 1'b1, 1'b1);
    serve(5, 2, -1);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start: got %b, required 0", bus.o_tx_start); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", bus.o_busy); end
    if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h, required 00", bus.o_tx_data); end
    if (bus.o_done_tick !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", bus.o_done_tick); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks += 2;
    if (bytes_q.size() != 5) begin errors++; $display("FAIL rstmid_abandon: got %0d starts, required 5", bytes_q.size()); end
    if (dones != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d, required 0", dones); end
    clear_mon();
    pulse_start(32'h04030201, 32'h01000080, 4'd10, 1'b0, 1'b1, 1'b1);
    serve(9, 1, -1);
    wait_done();
    checks++;
    if (bytes_q.size() != 9) begin errors++; $display("FAIL rstmid_fresh_count: got %0d starts, required 9", bytes_q.size()); end
    for (int k = 0; k < 9 && k < bytes_q.size(); k++) begin
      checks++;
      if (bytes_q[k] !== exp[k]) begin errors++; $display("FAIL rstmid_byte%0d: got %h, required %h", k, bytes_q[k], exp[k]); end
    end
  endtask

  task automatic test_loopback();
    logic [31:0] o, f, d_o, d_f;
    logic [7:0] ctrl;
    int base;
    clear_mon();
    for (int s = 0; s < 16; s++) begin
      o = 32'h10203040 + s * 32'h01010101;
      f = ~o + 32'(s);
      pulse_start(o, f, 4'(s), s[0], s[1], s[2]);
      serve(9, 0, -1);
      wait_done();
      base = s * 9;
      checks++;
      if (bytes_q.size() != base + 9) begin
        errors++;
        $display("FAIL loop_count%0d: got %0d bytes, required %0d", s, bytes_q.size(), base + 9);
      end else begin
        d_o = {bytes_q[base+3], bytes_q[base+2], bytes_q[base+1], bytes_q[base]};
        d_f = {bytes_q[base+7], bytes_q[base+6], bytes_q[base+5], bytes_q[base+4]};
        ctrl = bytes_q[base+8];
        checks += 5;
        if (d_o !== o) begin errors++; $display("FAIL loop_out%0d: got %h, required %h", s, d_o, o); end
        if (d_f !== f) begin errors++; $display("FAIL loop_freq%0d: got %h, required %h", s, d_f, f); end
        if (ctrl[7:4] !== 4'(s)) begin errors++; $display("FAIL loop_sel%0d: got %0d, required %0d", s, ctrl[7:4], s); end
        if (ctrl[3] !== 1'b0) begin errors++; $display("FAIL loop_pad%0d: got %b, required 0", s, ctrl[3]); end
        if (ctrl[2:0] !== {s[2], s[1], s[0]}) begin errors++; $display("FAIL loop_flags%0d: got %b, required %b", s, ctrl[2:0], s[2:0]); end
      end
    end
    checks += 2;
    if (frames != 1) begin errors++; $display("FAIL loop_frames: got %0d, required 1", frames); end
    if (dones != 16) begin errors++; $display("FAIL loop_dones: got %0d, required 16", dones); end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_output_pattern = '0;
    bus.i_freq_pattern = '0;
    bus.i_sel_out = '0;
    bus.i_ch_start = 1'b0;
    bus.i_ch_stop = 1'b0;
    bus.i_ch_mode = 1'b0;
    bus.i_tx_done_tick = 1'b0;
    test_reset();
    test_single();
    test_frame_end();
    test_busy_drop();
    test_handshake();
    test_reset_mid();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
